game_sequencer: RTL and testbench

Top-level round controller for the fishing game. It sequences the game datapath through title, clear, play, pause and game-over phases, and owns the round countdown and its 1 s prescaler. It also latches the session high score. It sits between the keyboard decoder (KBSTROBE/KBCODE) and the sprite/fish/score datapath, which it gates via RUN and clears via CLR.

---
 rtl/game_pkg.sv | 36 +++
 rtl/game_sequencer_sec_prescaler.sv | 32 +++
 rtl/game_sequencer.sv | 141 ++++++++++++++
 tb/tb_game_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the fishing game: phase encodings, keyboard scan codes
// and overlay colours keyed on the sequencer phase.
package game_pkg;

  localparam logic [2:0] ST_TITLE = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_START = 8'h29;
  localparam logic [7:0] SC_PAUSE = 8'h4D;
  localparam logic [7:0] SC_ABORT = 8'h76;

  localparam logic [11:0] COL_TITLE = 12'h00F;
  localparam logic [11:0] COL_CLEAR = 12'h000;
  localparam logic [11:0] COL_PLAY  = 12'h0AF;
  localparam logic [11:0] COL_PAUSE = 12'hFF0;
  localparam logic [11:0] COL_OVER  = 12'hF00;

  // Overlay tint the renderer applies for a given phase.
  function automatic logic [11:0] state_colour(input logic [2:0] s);
    case (s)
      ST_TITLE: state_colour = COL_TITLE;
      ST_CLEAR: state_colour = COL_CLEAR;
      ST_PLAY:  state_colour = COL_PLAY;
      ST_PAUSE: state_colour = COL_PAUSE;
      default:  state_colour = COL_OVER;
    endcase
  endfunction

endpackage

// File: rtl/game_sequencer_sec_prescaler.sv
// Game-second prescaler: counts 0..DIV-1 while enabled; wrap marks the last
// count of a second when enabled. last is ungated so callers can look ahead.
module sec_prescaler #(
  parameter int DIV = 25000000
) (
  input  logic CLK,
  input  logic arst_i,
  input  logic en,
  input  logic clr,
  output logic last,
  output logic wrap
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign last = (cnt == W'(DIV - 1));
  assign wrap = en && last;

  always_ff @(posedge CLK or posedge arst_i) begin
    if (arst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round controller: sequences TITLE/CLEAR/PLAY/PAUSE/OVER, owns the round
// countdown and the session high score, and gates the datapath via RUN/CLR.
module game_sequencer
  import game_pkg::*;
#(
  parameter int         TICK_DIV   = 25000000,
  parameter int         ROUND_SECS = 60,
  parameter int         CLR_CYCLES = 4,
  parameter int         OVER_SECS  = 5,
  parameter logic [7:0] KEY_START  = SC_START,
  parameter logic [7:0] KEY_PAUSE  = SC_PAUSE,
  parameter logic [7:0] KEY_ABORT  = SC_ABORT
) (
  input  logic        CLK,
  input  logic        arst_i,
  input  logic        KBSTROBE,
  input  logic [7:0]  KBCODE,
  input  logic [19:0] POINTS,
  output logic        RUN,
  output logic        CLR,
  output logic [2:0]  STATE,
  output logic [7:0]  SECS_LEFT,
  output logic        TICK,
  output logic [19:0] HISCORE,
  output logic        NEW_HI
);

  logic [3:0] clr_cnt;
  logic [7:0] over_cnt;
  logic       over_entry;
  logic       key_start, key_pause, key_abort;
  logic       pres_last, pres_wrap, pres_en, pres_clr;
  logic       final_sec, pause_take;

  assign key_start = KBSTROBE && (KBCODE == KEY_START);
  assign key_pause = KBSTROBE && (KBCODE == KEY_PAUSE);
  assign key_abort = KBSTROBE && (KBCODE == KEY_ABORT);

  // A pause only freezes the prescaler when it actually wins; on the final
  // second's wrap the timeout takes precedence and the count must run out.
  assign final_sec  = pres_last && (SECS_LEFT <= 8'd1);
  assign pause_take = (STATE == ST_PLAY) && key_pause && !key_abort && !final_sec;
  assign pres_en    = ((STATE == ST_PLAY) && !pause_take) || (STATE == ST_OVER);
  assign pres_clr   = (STATE == ST_TITLE) || (STATE == ST_CLEAR);

  sec_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .CLK    (CLK),
    .arst_i (arst_i),
    .en     (pres_en),
    .clr    (pres_clr),
    .last   (pres_last),
    .wrap   (pres_wrap)
  );

  always_ff @(posedge CLK or posedge arst_i) begin
    if (arst_i) begin
      STATE      <= ST_TITLE;
      RUN        <= 1'b0;
      CLR        <= 1'b0;
      SECS_LEFT  <= 8'(ROUND_SECS);
      TICK       <= 1'b0;
      HISCORE    <= '0;
      NEW_HI     <= 1'b0;
      clr_cnt    <= '0;
      over_cnt   <= '0;
      over_entry <= 1'b0;
    end else begin
      TICK <= 1'b0;
      case (STATE)
        ST_TITLE: begin
          RUN <= 1'b0;
          if (key_start) begin
            STATE     <= ST_CLEAR;
            CLR       <= 1'b1;
            clr_cnt   <= '0;
            SECS_LEFT <= 8'(ROUND_SECS);
            NEW_HI    <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == 4'(CLR_CYCLES - 1)) begin
            STATE <= ST_PLAY;
            CLR   <= 1'b0;
            RUN   <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 4'd1;
          end
        end
        ST_PLAY: begin
          if (key_abort) begin
            STATE <= ST_TITLE;
            RUN   <= 1'b0;
          end else if (pres_wrap) begin
            TICK <= 1'b1;
            if (SECS_LEFT != 8'd0) SECS_LEFT <= SECS_LEFT - 8'd1;
            if (SECS_LEFT <= 8'd1) begin
              STATE      <= ST_OVER;
              RUN        <= 1'b0;
              over_entry <= 1'b1;
              over_cnt   <= '0;
            end
          end else if (key_pause) begin
            STATE <= ST_PAUSE;
            RUN   <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (key_abort) begin
            STATE <= ST_TITLE;
          end else if (key_pause) begin
            STATE <= ST_PLAY;
            RUN   <= 1'b1;
          end
        end
        ST_OVER: begin
          over_entry <= 1'b0;
          if (over_entry && (POINTS > HISCORE)) begin
            HISCORE <= POINTS;
            NEW_HI  <= 1'b1;
          end
          if (key_start) begin
            STATE     <= ST_CLEAR;
            CLR       <= 1'b1;
            clr_cnt   <= '0;
            SECS_LEFT <= 8'(ROUND_SECS);
            NEW_HI    <= 1'b0;
          end else if (pres_wrap) begin
            if (over_cnt == 8'(OVER_SECS - 1)) STATE <= ST_TITLE;
            else                                over_cnt <= over_cnt + 8'd1;
          end
        end
        default: begin
          STATE <= ST_TITLE;
          RUN   <= 1'b0;
          CLR   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed rounds; a monitor pops expected phases on
// every STATE change and expected SECS_LEFT on every TICK.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int TD = 10;
  localparam int RS = 3;
  localparam int CC = 4;
  localparam int OS = 5;

  logic        CLK = 1'b0;
  logic        arst_i = 1'b0;
  logic        KBSTROBE = 1'b0;
  logic [7:0]  KBCODE = 8'h00;
  logic [19:0] POINTS = '0;
  logic        RUN, CLR, TICK, NEW_HI;
  logic [2:0]  STATE;
  logic [7:0]  SECS_LEFT;
  logic [19:0] HISCORE;

  game_sequencer #(
    .TICK_DIV(TD), .ROUND_SECS(RS), .CLR_CYCLES(CC), .OVER_SECS(OS)
  ) dut (
    .CLK(CLK), .arst_i(arst_i), .KBSTROBE(KBSTROBE), .KBCODE(KBCODE),
    .POINTS(POINTS), .RUN(RUN), .CLR(CLR), .STATE(STATE),
    .SECS_LEFT(SECS_LEFT), .TICK(TICK), .HISCORE(HISCORE), .NEW_HI(NEW_HI)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [7:0] exp_secs_q[$];
  bit         mon_on = 1'b0;
  logic [2:0] prev_state;
  int         clr_seen = 0;

  always @(negedge CLK) begin
    logic [2:0] es;
    logic [7:0] ev;
    if (CLR === 1'b1) clr_seen++;
    if (mon_on) begin
      if (STATE !== prev_state) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL state_change: got %0d, no change expected", STATE);
        end else begin
          es = exp_q.pop_front();
          if (STATE !== es) begin
            errors++;
            $display("FAIL state_change: got %0d, expected %0d", STATE, es);
          end
        end
        prev_state = STATE;
      end
      if (TICK === 1'b1) begin
        checks++;
        if (exp_secs_q.size() == 0) begin
          errors++;
          $display("FAIL tick_secs: TICK with SECS_LEFT=%0d, no tick expected", SECS_LEFT);
        end else begin
          ev = exp_secs_q.pop_front();
          if (SECS_LEFT !== ev) begin
            errors++;
            $display("FAIL tick_secs: got %0d, expected %0d", SECS_LEFT, ev);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    KBCODE = code;
    KBSTROBE = 1'b1;
    @(posedge CLK);
    #1;
    KBSTROBE = 1'b0;
    KBCODE = 8'h00;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output int n);
    n = 0;
    while (STATE !== s && n < max) begin
      step(1);
      n++;
    end
    if (STATE !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: state %0d, expected %0d within %0d cycles", STATE, s, max);
    end
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (TICK !== 1'b1 && n < max);
    if (TICK !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: no TICK within %0d cycles", max);
    end
  endtask

  task automatic push_ticks(input int upto);
    for (int s = RS - 1; s >= upto; s--) exp_secs_q.push_back(8'(s));
  endtask

  initial begin
    int n, c0, t_over;
    #1 arst_i = 1'b1;
    #1;
    chk("rst_state", STATE, ST_TITLE);
    chk("rst_run", RUN, 0);
    chk("rst_clr", CLR, 0);
    chk("rst_secs", SECS_LEFT, RS);
    chk("rst_tick", TICK, 0);
    chk("rst_hiscore", HISCORE, 0);
    chk("rst_new_hi", NEW_HI, 0);
    #10;
    @(negedge CLK) arst_i = 1'b0;
    step(1);
    prev_state = STATE;
    mon_on = 1'b1;

    press(SC_W);
    step(2);
    chk("title_ignores_w", STATE, ST_TITLE);

    // Round 1: full countdown, first high score, auto-return to TITLE.
    POINTS = 20'd25;
    exp_q.push_back(ST_CLEAR); exp_q.push_back(ST_PLAY);
    exp_q.push_back(ST_OVER);  exp_q.push_back(ST_TITLE);
    push_ticks(0);
    clr_seen = 0;
    press(SC_START);
    c0 = cyc;
    chk("clear_clr_high", CLR, 1);
    press(SC_START);
    wait_state(ST_PLAY, 20, n);
    chk("clear_len", cyc - c0, CC);
    chk("clr_pulse_cycles", clr_seen, CC);
    chk("play_run", RUN, 1);
    chk("play_clr_low", CLR, 0);
    chk("play_secs_loaded", SECS_LEFT, RS);
    wait_tick(30, n); chk("tick_period_a", n, TD);
    wait_tick(30, n); chk("tick_period_b", n, TD);
    wait_tick(30, n); chk("tick_period_c", n, TD);
    chk("over_on_last_tick", STATE, ST_OVER);
    chk("run_low_at_over", RUN, 0);
    t_over = cyc;
    step(2);
    chk("hiscore_first", HISCORE, 25);
    chk("new_hi_first", NEW_HI, 1);
    wait_state(ST_TITLE, 100, n);
    chk("over_hold_len", cyc - t_over, OS * TD);
    chk("new_hi_held_title", NEW_HI, 1);

    // Round 2: equal score does not update; restart straight from OVER.
    exp_q.push_back(ST_CLEAR); exp_q.push_back(ST_PLAY);
    exp_q.push_back(ST_OVER);  exp_q.push_back(ST_CLEAR);
    push_ticks(0);
    press(SC_START);
    step(1);
    chk("new_hi_cleared", NEW_HI, 0);
    wait_state(ST_OVER, 100, n);
    step(2);
    chk("hiscore_equal", HISCORE, 25);
    chk("new_hi_equal", NEW_HI, 0);
    press(SC_START);
    chk("restart_from_over", STATE, ST_CLEAR);

    // Round 3: pause at prescaler 6 with 2 s left, resume, higher score.
    POINTS = 20'd26;
    exp_q.push_back(ST_PLAY); exp_q.push_back(ST_PAUSE);
    exp_q.push_back(ST_PLAY); exp_q.push_back(ST_OVER);
    exp_q.push_back(ST_CLEAR);
    push_ticks(0);
    wait_state(ST_PLAY, 20, n);
    wait_tick(30, n);
    step(6);
    press(SC_PAUSE);
    chk("pause_state", STATE, ST_PAUSE);
    chk("pause_run", RUN, 0);
    step(50);
    chk("pause_secs_frozen", SECS_LEFT, 2);
    press(SC_PAUSE);
    chk("resume_run", RUN, 1);
    wait_tick(30, n);
    chk("resume_tick_delay", n, 4);
    wait_state(ST_OVER, 100, n);
    step(2);
    chk("hiscore_higher", HISCORE, 26);
    chk("new_hi_higher", NEW_HI, 1);
    press(SC_START);

    // Round 4: abort on the final tick cycle wins over timeout.
    POINTS = 20'd99;
    exp_q.push_back(ST_PLAY); exp_q.push_back(ST_TITLE);
    push_ticks(1);
    wait_state(ST_PLAY, 20, n);
    wait_tick(30, n);
    wait_tick(30, n);
    step(TD - 1);
    press(SC_ABORT);
    chk("abort_final_state", STATE, ST_TITLE);
    chk("abort_final_tick", TICK, 0);
    step(2);
    chk("abort_hiscore_kept", HISCORE, 26);

    // Round 5: pause on the final tick cycle loses to timeout.
    POINTS = 20'd20;
    exp_q.push_back(ST_CLEAR); exp_q.push_back(ST_PLAY);
    exp_q.push_back(ST_OVER);
    push_ticks(0);
    press(SC_START);
    wait_state(ST_PLAY, 20, n);
    wait_tick(30, n);
    wait_tick(30, n);
    step(TD - 1);
    press(SC_PAUSE);
    chk("pause_final_state", STATE, ST_OVER);
    chk("pause_final_secs", SECS_LEFT, 0);
    step(2);
    chk("lower_hiscore_kept", HISCORE, 26);
    chk("lower_new_hi", NEW_HI, 0);

    // Round 6: asynchronous reset mid-round with 1 s left.
    exp_q.push_back(ST_CLEAR); exp_q.push_back(ST_PLAY);
    exp_q.push_back(ST_TITLE);
    push_ticks(1);
    press(SC_START);
    wait_state(ST_PLAY, 20, n);
    wait_tick(30, n);
    wait_tick(30, n);
    step(3);
    chk("pre_reset_secs", SECS_LEFT, 1);
    #1 arst_i = 1'b1;
    #1;
    chk("arst_state", STATE, ST_TITLE);
    chk("arst_run", RUN, 0);
    chk("arst_secs", SECS_LEFT, RS);
    chk("arst_hiscore", HISCORE, 0);
    chk("arst_new_hi", NEW_HI, 0);
    step(3);
    @(negedge CLK) arst_i = 1'b0;
    step(3);

    chk("state_q_drained", exp_q.size(), 0);
    chk("secs_q_drained", exp_secs_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
